// File: rtl/pixel_offset_stream.sv
// pixel_offset_stream: 2-stage valid/ready pixel brightness offset with saturate/wrap and frame tracking.
// Define CLIP_STATS_EN to build the per-frame clipped-channel counter behind sat_count_o.
module pixel_offset_stream #(
    parameter int DATA_W       = 8,
    parameter int CHANNELS     = 3,
    parameter int FRAME_PIXELS = 2100,
    parameter int CNT_W        = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         s_valid_i,
    output logic                         s_ready_o,
    input  logic [CHANNELS*DATA_W-1:0]   s_data_i,
    input  logic [DATA_W:0]              offset_i,
    input  logic                         sat_en_i,
    output logic                         m_valid_o,
    input  logic                         m_ready_i,
    output logic [CHANNELS*DATA_W-1:0]   m_data_o,
    output logic                         m_last_o,
    output logic                         frame_done_o,
    output logic [CNT_W-1:0]             sat_count_o
);
    localparam int PW  = CHANNELS * DATA_W;
    localparam int SW  = DATA_W + 2;
    localparam int PCW = FRAME_PIXELS > 1 ? $clog2(FRAME_PIXELS) : 1;
    logic [PCW-1:0]         pix_cnt_q, pix_cnt_d;
    logic [DATA_W:0]        off_q, off_d, off_use;
    logic                   sat_q, sat_d, sat_use;
    logic                   s1_valid_q, s1_valid_d, s1_last_q, s1_last_d, s1_sat_q, s1_sat_d;
    logic [CHANNELS*SW-1:0] s1_sum_q, s1_sum_d;
    logic                   m_valid_q, m_valid_d, m_last_q, m_last_d, frame_done_q;
    logic [PW-1:0]          m_data_q, m_data_d;
    logic [CHANNELS-1:0]    neg, over;
    logic                   en, accept, first, last_in, m_fire, m_ld;
    assign s_ready_o    = en;
    assign m_valid_o    = m_valid_q;
    assign m_data_o     = m_data_q;
    assign m_last_o     = m_last_q;
    assign frame_done_o = frame_done_q;
    // Pixel 0 of a frame uses the live offset/mode; the rest of the frame uses the latched copy.
    always_comb begin
        en        = !m_valid_q | m_ready_i;
        accept    = s_valid_i & en;
        first     = pix_cnt_q == '0;
        last_in   = pix_cnt_q == PCW'(FRAME_PIXELS - 1);
        off_use   = first ? offset_i : off_q;
        sat_use   = first ? sat_en_i : sat_q;
        m_fire    = m_valid_q & m_ready_i;
        m_ld      = en & s1_valid_q;
        pix_cnt_d = accept ? (last_in ? '0 : pix_cnt_q + PCW'(1)) : pix_cnt_q;
        off_d     = accept ? off_use : off_q;
        sat_d     = accept ? sat_use : sat_q;
        s1_valid_d = en ? accept : s1_valid_q;
        s1_last_d  = en ? accept & last_in : s1_last_q;
        s1_sat_d   = en ? sat_use : s1_sat_q;
        m_valid_d  = en ? s1_valid_q : m_valid_q;
        m_last_d   = en ? s1_last_q : m_last_q;
        s1_sum_d   = s1_sum_q;
        m_data_d   = m_data_q;
        neg        = '0;
        over       = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (en)
                s1_sum_d[k*SW +: SW] = {2'b00, s_data_i[k*DATA_W +: DATA_W]} + {off_use[DATA_W], off_use};
            neg[k]  = s1_sum_q[k*SW + SW - 1];
            over[k] = !neg[k] & s1_sum_q[k*SW + DATA_W];
            if (m_ld)
                m_data_d[k*DATA_W +: DATA_W] = !s1_sat_q ? s1_sum_q[k*SW +: DATA_W] :
                                               neg[k]    ? '0 :
                                               over[k]   ? '1 : s1_sum_q[k*SW +: DATA_W];
        end
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pix_cnt_q    <= '0;
            off_q        <= '0;
            sat_q        <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_sat_q     <= 1'b0;
            s1_sum_q     <= '0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            m_data_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            pix_cnt_q    <= pix_cnt_d;
            off_q        <= off_d;
            sat_q        <= sat_d;
            s1_valid_q   <= s1_valid_d;
            s1_last_q    <= s1_last_d;
            s1_sat_q     <= s1_sat_d;
            s1_sum_q     <= s1_sum_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
            m_data_q     <= m_data_d;
            frame_done_q <= m_fire & m_last_q;
        end
    end
`ifdef CLIP_STATS_EN
    localparam int CW = $clog2(CHANNELS + 1);
    logic [CW-1:0]    clip_n;
    logic [CNT_W:0]   stat_sum;
    logic [CNT_W-1:0] stat_cnt_q, stat_cnt_d, sat_count_q, sat_count_d;
    assign sat_count_o = sat_count_q;
    // Counted as pixels leave S1; the m_last transfer snapshots and restarts with any pixel moving alongside.
    always_comb begin
        clip_n = '0;
        for (int k = 0; k < CHANNELS; k++)
            clip_n = clip_n + CW'(m_ld & (neg[k] | over[k]));
        stat_sum    = {1'b0, stat_cnt_q} + (CNT_W + 1)'(clip_n);
        stat_cnt_d  = (m_fire & m_last_q) ? CNT_W'(clip_n) : stat_sum[CNT_W] ? '1 : stat_sum[CNT_W-1:0];
        sat_count_d = (m_fire & m_last_q) ? stat_cnt_q : sat_count_q;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stat_cnt_q  <= '0;
            sat_count_q <= '0;
        end else begin
            stat_cnt_q  <= stat_cnt_d;
            sat_count_q <= sat_count_d;
        end
    end
`else
    assign sat_count_o = '0;
`endif
endmodule

// File: tb/tb_pixel_offset_stream.sv
// tb_pixel_offset_stream: scoreboard bench with a per-pixel arithmetic reference model.
module tb_pixel_offset_stream;
    localparam int FP = 4;
`ifdef CLIP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    typedef struct {
        logic [23:0] d;
        logic        l;
        int          clips;
    } exp_t;
    logic        clk = 1'b0, rst_n = 1'b0, s_valid = 1'b0, s_ready, sat_en = 1'b0;
    logic        m_valid, m_ready = 1'b0, m_last, frame_done;
    logic [23:0] s_data = '0, m_data;
    logic [8:0]  offset = '0;
    logic [15:0] sat_count;
    exp_t        sb[$];
    int          vectors = 0, miscompares = 0;
    int          idx = 0;
    logic signed [8:0] f_off = '0;
    logic        f_sat = 1'b0;
    pixel_offset_stream #(.DATA_W(8), .CHANNELS(3), .FRAME_PIXELS(FP), .CNT_W(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .s_valid_i(s_valid), .s_ready_o(s_ready),
        .s_data_i(s_data), .offset_i(offset), .sat_en_i(sat_en), .m_valid_o(m_valid),
        .m_ready_i(m_ready), .m_data_o(m_data), .m_last_o(m_last),
        .frame_done_o(frame_done), .sat_count_o(sat_count)
    );
    always #5 clk = ~clk;
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", n, act, req, $time);
        end
    endtask
    function automatic exp_t model(input logic [23:0] d, input logic signed [8:0] off,
                                   input logic se, input logic l);
        exp_t r;
        r.d = '0;
        r.l = l;
        r.clips = 0;
        for (int c = 0; c < 3; c++) begin
            int v;
            v = int'(d[c*8 +: 8]) + int'(off);
            if (v < 0 || v > 255) r.clips++;
            if (se) v = v < 0 ? 0 : (v > 255 ? 255 : v);
            else    v = v & 255;
            r.d[c*8 +: 8] = 8'(v);
        end
        return r;
    endfunction
    task automatic cyc(input logic sv, input logic [23:0] d, input logic [8:0] off,
                       input logic se, input logic mr, input logic rn, output logic acc);
        @(negedge clk);
        rst_n = rn; s_valid = sv; s_data = d; offset = off; sat_en = se; m_ready = mr;
        acc = 1'b0;
        if (!rn) begin
            sb.delete();
            idx = 0;
        end
        #1;
        if (rn && sv && s_ready) begin
            acc = 1'b1;
            if (idx == 0) begin
                f_off = off;
                f_sat = se;
            end
            sb.push_back(model(d, f_off, f_sat, idx == FP - 1));
            idx = (idx + 1) % FP;
        end
    endtask
    // Monitor: samples mid-cycle, after the driver has settled its inputs.
    logic        prev_rst = 1'b0, done_pend = 1'b0, held_v = 1'b0, held_l = 1'b0;
    logic [23:0] held_d = '0;
    int          acc_clips = 0, exp_sat = 0;
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (prev_rst) begin
            chk("rst_m_valid", 32'(m_valid), 0);
            chk("rst_m_data", 32'(m_data), 0);
            chk("rst_m_last", 32'(m_last), 0);
            chk("rst_frame_done", 32'(frame_done), 0);
            chk("rst_sat_count", 32'(sat_count), 0);
        end
        if (!rst_n) begin
            prev_rst = 1'b1; acc_clips = 0; exp_sat = 0; done_pend = 1'b0; held_v = 1'b0;
        end else begin
            prev_rst = 1'b0;
            chk("frame_done", 32'(frame_done), 32'(done_pend));
            chk("sat_count", 32'(sat_count), 32'(exp_sat));
            if (held_v) begin
                chk("hold_valid", 32'(m_valid), 1);
                chk("hold_data", 32'(m_data), 32'(held_d));
                chk("hold_last", 32'(m_last), 32'(held_l));
            end
            held_v = m_valid && !m_ready; held_d = m_data; held_l = m_last;
            if (held_v) chk("stall_s_ready", 32'(s_ready), 0);
            done_pend = 1'b0;
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 32'(m_data), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("m_data", 32'(m_data), 32'(e.d));
                    chk("m_last", 32'(m_last), 32'(e.l));
                    acc_clips += e.clips;
                    if (e.l) begin
                        exp_sat = STATS ? acc_clips : 0;
                        acc_clips = 0;
                        done_pend = 1'b1;
                    end
                end
            end
        end
    end
    initial begin
        logic a;
        int p, c;
        logic [23:0] d;
        repeat (3) cyc(1'b1, 24'h123456, 9'd1, 1'b1, 1'b1, 1'b0, a);
        for (int i = 0; i < FP; i++) cyc(1'b1, 24'h1020FE, 9'd3, 1'b1, 1'b1, 1'b1, a);
        for (int i = 0; i < FP; i++) cyc(1'b1, 24'h0000FE, 9'd3, 1'b0, 1'b1, 1'b1, a);
        for (int i = 0; i < FP; i++) cyc(1'b1, 24'h1040FF, 9'h1E0, 1'b1, 1'b1, 1'b1, a);
        p = 0; c = 0;
        while (p < 8 && c < 100) begin
            d = {8'(p * 3), 8'(8'hF8 + p), 8'(p * 32)};
            cyc(1'b1, d, p >= 2 ? 9'd5 : 9'd3, 1'b1, !(c >= 3 && c < 8), 1'b1, a);
            if (a) p++;
            c++;
        end
        cyc(1'b1, 24'hAAAAAA, 9'd9, 1'b0, 1'b1, 1'b1, a);
        cyc(1'b1, 24'hBBBBBB, 9'd9, 1'b0, 1'b1, 1'b1, a);
        cyc(1'b1, 24'hCCCCCC, 9'd9, 1'b0, 1'b1, 1'b0, a);
        for (int i = 0; i < 6; i++) cyc(1'b1, 24'(i * 24'h0F0F0F), 9'h1F9, 1'b1, 1'b1, 1'b1, a);
        for (int i = 0; i < 800; i++)
            cyc($urandom_range(0, 3) != 0, 24'($urandom), 9'($urandom), 1'($urandom),
                $urandom_range(0, 3) != 0, $urandom_range(0, 99) != 0, a);
        c = 0;
        while (sb.size() != 0 && c < 50) begin
            cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, a);
            c++;
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d pixels outstanding, expected 0", sb.size());
        end
        repeat (3) cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, a);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
